// File: rtl/int_to_float_converter_if.sv
// Valid/ready handshake bundle between an integer producer and the int->float converter.
// The master is the producer/consumer side; the slave is the converter.
interface int_to_float_converter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        inexact;

    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_data, inexact
    );

    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_data, inexact
    );
endinterface

// File: rtl/int_to_float_converter.sv
// Sequential 32-bit integer to IEEE-754 single converter: one-bit-per-cycle normalisation,
// then optional round-to-nearest-even, one conversion in flight.
module int_to_float_converter #(
    parameter bit ROUND_MODE = 1'b1
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    int_to_float_converter_if.slave      bus,
    output logic                         busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t      state;
    logic        sign;
    logic [31:0] mag;
    logic [7:0]  exp_q;
    logic        out_valid;
    logic [31:0] out_data;
    logic        inexact;

    logic        in_sign;
    logic [22:0] mant_raw;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] mant_sum;

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.inexact   = inexact;
    assign busy          = (state != S_IDLE);

    // NOTE: every signal written here gets a value first, so no path can leave one unassigned (no latch).
    always_comb begin
        in_sign  = 1'b0;
        mant_raw = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        round_up = 1'b0;
        mant_sum = '0;

        in_sign  = bus.in_signed & bus.in_data[31];
        mant_raw = mag[30:8];
        guard    = mag[7];
        sticky   = |mag[6:0];
        round_up = ROUND_MODE && guard && (sticky || mant_raw[0]);
        // A carry into bit 23 leaves the low 23 bits at zero, which is exactly the renormalised mantissa.
        mant_sum = {1'b0, mant_raw} + {23'd0, round_up};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            sign      <= 1'b0;
            mag       <= '0;
            exp_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            inexact   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        sign  <= in_sign;
                        mag   <= in_sign ? (~bus.in_data + 32'd1) : bus.in_data;
                        exp_q <= 8'd158;
                        if (bus.in_data == 32'd0) begin
                            out_data <= '0;
                            inexact  <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            state <= S_NORM;
                        end
                    end
                end

                S_NORM: begin
                    if (mag[31]) begin
                        state <= S_ROUND;
                    end else begin
                        mag   <= {mag[30:0], 1'b0};
                        exp_q <= exp_q - 8'd1;
                    end
                end

                S_ROUND: begin
                    out_data  <= {sign, exp_q + {7'd0, mant_sum[23]}, mant_sum[22:0]};
                    inexact   <= guard | sticky;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end

                S_DONE: begin
                    // The zero shortcut enters DONE with out_valid low; it is raised one cycle later.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_float_converter.sv
// Scoreboard bench: a driver pushes hand-computed results for an RNE and a truncating converter;
// a negedge monitor compares latency, data, inexact and handshake behaviour.
module tb_int_to_float_converter;

    typedef struct {
        logic [31:0] d_rne;
        logic [31:0] d_tr;
        logic        x_rne;
        logic        x_tr;
        int          lat;
        longint      t;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic        s;
        logic [31:0] rne;
        logic [31:0] tr;
        logic        xr;
        logic        xt;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_signed = 1'b0;
    logic        out_ready = 1'b1;
    logic        busy_rne;
    logic        busy_tr;

    logic        ov [2];
    logic        ir [2];
    logic [31:0] od [2];
    logic        ix [2];
    logic        bz [2];
    logic        pv [2];

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;
    exp_t sb[$];
    vec_t vecs[$];

    int_to_float_converter_if bus_rne ();
    int_to_float_converter_if bus_tr ();

    assign bus_rne.in_valid  = in_valid;
    assign bus_rne.in_data   = in_data;
    assign bus_rne.in_signed = in_signed;
    assign bus_rne.out_ready = out_ready;
    assign bus_tr.in_valid   = in_valid;
    assign bus_tr.in_data    = in_data;
    assign bus_tr.in_signed  = in_signed;
    assign bus_tr.out_ready  = out_ready;

    assign ov[0] = bus_rne.out_valid;
    assign ir[0] = bus_rne.in_ready;
    assign od[0] = bus_rne.out_data;
    assign ix[0] = bus_rne.inexact;
    assign bz[0] = busy_rne;
    assign ov[1] = bus_tr.out_valid;
    assign ir[1] = bus_tr.in_ready;
    assign od[1] = bus_tr.out_data;
    assign ix[1] = bus_tr.inexact;
    assign bz[1] = busy_tr;

    int_to_float_converter #(.ROUND_MODE(1'b1)) dut_rne (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus_rne),
        .busy     (busy_rne)
    );

    int_to_float_converter #(.ROUND_MODE(1'b0)) dut_tr (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus_tr),
        .busy     (busy_tr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic bound_fail(input string name, input bit expired);
        total++;
        if (expired) begin
            bad++;
            $display("FAIL %s: wait bound expired", name);
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rst) begin
            pv[0] = 1'b0;
            pv[1] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (ov[d]) begin
                    if (sb.size() == 0) begin
                        check($sformatf("d%0d_spurious_valid", d), 32'(ov[d]), 32'd0);
                    end else begin
                        if (!pv[d])
                            check($sformatf("d%0d_latency", d),
                                  32'(int'(($time - sb[0].t - 5) / 10)), 32'(sb[0].lat));
                        check($sformatf("d%0d_data", d), od[d], (d == 0) ? sb[0].d_rne : sb[0].d_tr);
                        check($sformatf("d%0d_inexact", d), 32'(ix[d]),
                              32'((d == 0) ? sb[0].x_rne : sb[0].x_tr));
                    end
                    check($sformatf("d%0d_in_ready_in_done", d), 32'(ir[d]), 32'd0);
                    check($sformatf("d%0d_busy_in_done", d), 32'(bz[d]), 32'd1);
                end
                pv[d] = ov[d];
            end
            if (ov[0] && out_ready && sb.size() > 0) begin
                check("valid_lockstep", 32'(ov[1]), 32'd1);
                void'(sb.pop_front());
                hs_cnt++;
            end
        end
    end

    task automatic send(input vec_t v);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!(ir[0] && ir[1]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        bound_fail("accept_wait", n >= 200);
        in_valid  = 1'b1;
        in_data   = v.d;
        in_signed = v.s;
        @(posedge clk);
        e.d_rne = v.rne;
        e.d_tr  = v.tr;
        e.x_rne = v.xr;
        e.x_tr  = v.xt;
        e.lat   = v.lat;
        e.t     = longint'($time);
        sb.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !ir[0]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        bound_fail("drain_wait", n >= 100);
    endtask

    initial begin
        int hs_before;
        int n;

        vecs.push_back('{32'h00000001, 1'b0, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 33});
        vecs.push_back('{32'hFFFFFFFF, 1'b1, 32'hBF800000, 32'hBF800000, 1'b0, 1'b0, 33});
        vecs.push_back('{32'h80000000, 1'b1, 32'hCF000000, 32'hCF000000, 1'b0, 1'b0, 2});
        vecs.push_back('{32'hFFFFFFFF, 1'b0, 32'h4F800000, 32'h4F7FFFFF, 1'b1, 1'b1, 2});
        vecs.push_back('{32'h01000001, 1'b0, 32'h4B800000, 32'h4B800000, 1'b1, 1'b1, 9});
        vecs.push_back('{32'h01000003, 1'b0, 32'h4B800002, 32'h4B800001, 1'b1, 1'b1, 9});
        vecs.push_back('{32'h00000000, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1});
        vecs.push_back('{32'h12345678, 1'b0, 32'h4D91A2B4, 32'h4D91A2B3, 1'b1, 1'b1, 5});
        vecs.push_back('{32'hFFFFFFFD, 1'b1, 32'hC0400000, 32'hC0400000, 1'b0, 1'b0, 32});
        vecs.push_back('{32'h80000000, 1'b0, 32'h4F000000, 32'h4F000000, 1'b0, 1'b0, 2});
        vecs.push_back('{32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1});

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(ir[0]), 32'd1);
        check("reset_out_valid", 32'(ov[0]), 32'd0);
        check("reset_out_data", od[0], 32'd0);
        check("reset_inexact", 32'(ix[0]), 32'd0);
        check("reset_busy", 32'(bz[0]), 32'd0);

        foreach (vecs[i]) begin
            send(vecs[i]);
            drain();
        end

        // Backpressure: result held in DONE while in_valid pulses are ignored.
        out_ready = 1'b0;
        send(vecs[7]);
        n = 0;
        while (!ov[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        bound_fail("bp_valid_wait", n >= 50);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid_held", 32'(ov[0]), 32'd1);
            in_valid  = (c % 2 == 0);
            in_data   = 32'h0000_0005 + 32'(c);
            in_signed = 1'b0;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        hs_before = hs_cnt;
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("bp_one_handshake", 32'(hs_cnt), 32'(hs_before + 1));
        check("bp_in_ready_after", 32'(ir[0]), 32'd1);
        check("bp_out_valid_after", 32'(ov[0]), 32'd0);
        drain();

        // Reset in the middle of normalisation discards the operand.
        send(vecs[0]);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("mid_norm_busy", 32'(bz[0]), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst_mid_in_ready", 32'(ir[0]), 32'd1);
        check("rst_mid_out_valid", 32'(ov[0]), 32'd0);
        check("rst_mid_busy", 32'(bz[0]), 32'd0);
        send('{32'd3, 1'b0, 32'h40400000, 32'h40400000, 1'b0, 1'b0, 32});
        drain();

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
